// File: rtl/pc_pkg.sv
// ============================================================================
// Module : pc_pkg
// Brief  : Shared types and default vectors for the program-counter unit.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package pc_pkg;

  // Numeric encoding doubles as redirect priority (higher wins).
  typedef enum logic [2:0] {
    KIND_NONE   = 3'd0,
    KIND_BRANCH = 3'd1,
    KIND_JUMP   = 3'd2,
    KIND_ERET   = 3'd3,
    KIND_EXC    = 3'd4
  } redirect_kind_t;

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } pc_state_t;

  localparam logic [31:0] C_DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] C_DEF_EXC_VEC   = 32'h0000_0180;

endpackage

`default_nettype wire

// File: rtl/pc_redirect_arb.sv
// ============================================================================
// Module : pc_redirect_arb
// Brief  : Priority select of redirect kind/target: exc > eret > jump > branch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_redirect_arb
  import pc_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              eret_valid,
  input  logic [ADDR_W-1:0] epc,
  output redirect_kind_t    kind,
  output logic [ADDR_W-1:0] target
);

  // For an exception the target carries the faulting PC destined for epc.
  always_comb begin
    kind   = KIND_NONE;
    target = '0;
    if (exc_valid) begin
      kind   = KIND_EXC;
      target = exc_pc;
    end else if (eret_valid) begin
      kind   = KIND_ERET;
      target = epc;
    end else if (jump_valid) begin
      kind   = KIND_JUMP;
      target = jump_target;
    end else if (branch_valid) begin
      kind   = KIND_BRANCH;
      target = branch_target;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module : pc_sequencer
// Brief  : Hit-gated PC with redirect buffering during fetch stalls and EPC.
//          Optional macro PC_ALIGN_CHK_EN adds misaligned-target trapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pc_sequencer
  import pc_pkg::*;
#(
  parameter int                ADDR_W      = 32,
  parameter int                INSTR_BYTES = 4,
  parameter logic [ADDR_W-1:0] RESET_VEC   = ADDR_W'(C_DEF_RESET_VEC),
  parameter logic [ADDR_W-1:0] EXC_VEC     = ADDR_W'(C_DEF_EXC_VEC)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              hit,
  input  logic              branch_valid,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              exc_valid,
  input  logic [ADDR_W-1:0] exc_pc,
  input  logic              eret_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic [ADDR_W-1:0] epc,
  output logic              redirect_pending,
  output logic              flush
`ifdef PC_ALIGN_CHK_EN
  ,
  output logic              align_err
`endif
);

  localparam logic [ADDR_W-1:0] C_STEP       = ADDR_W'(INSTR_BYTES);
  localparam logic [ADDR_W-1:0] C_ALIGN_MASK = ADDR_W'(INSTR_BYTES - 1);

  pc_state_t         r_state;
  redirect_kind_t    r_pend_kind;
  logic [ADDR_W-1:0] r_pend_target;
  redirect_kind_t    w_kind;
  logic [ADDR_W-1:0] w_target;
  logic              w_accept;
  logic              w_misaligned;

  pc_redirect_arb #(.ADDR_W(ADDR_W)) u_arb (
    .branch_valid  (branch_valid),
    .branch_target (branch_target),
    .jump_valid    (jump_valid),
    .jump_target   (jump_target),
    .exc_valid     (exc_valid),
    .exc_pc        (exc_pc),
    .eret_valid    (eret_valid),
    .epc           (epc),
    .kind          (w_kind),
    .target        (w_target)
  );

  assign pc_next_seq      = pc + C_STEP;
  assign redirect_pending = (r_state == ST_HOLD);

  // In HOLD a new redirect replaces the pending one only at equal or higher priority.
  assign w_accept = (w_kind != KIND_NONE) && (w_kind != KIND_EXC) &&
                    ((r_state == ST_RUN) || (w_kind >= r_pend_kind));

`ifdef PC_ALIGN_CHK_EN
  assign w_misaligned = (w_target & C_ALIGN_MASK) != '0;
`else
  assign w_misaligned = 1'b0;
`endif

  always_ff @(negedge clock) begin
    if (reset) begin
      pc            <= RESET_VEC;
      epc           <= '0;
      flush         <= 1'b0;
      r_state       <= ST_RUN;
      r_pend_kind   <= KIND_NONE;
      r_pend_target <= '0;
`ifdef PC_ALIGN_CHK_EN
      align_err     <= 1'b0;
`endif
    end else begin
      flush <= 1'b0;
`ifdef PC_ALIGN_CHK_EN
      align_err <= 1'b0;
`endif
      if (w_kind == KIND_EXC || (w_accept && w_misaligned)) begin
        pc          <= EXC_VEC;
        epc         <= w_target;
        flush       <= 1'b1;
        r_state     <= ST_RUN;
        r_pend_kind <= KIND_NONE;
`ifdef PC_ALIGN_CHK_EN
        align_err   <= (w_kind != KIND_EXC);
`endif
      end else if (w_accept) begin
        if (hit) begin
          pc          <= w_target;
          flush       <= 1'b1;
          r_state     <= ST_RUN;
          r_pend_kind <= KIND_NONE;
        end else begin
          r_pend_target <= w_target;
          r_pend_kind   <= w_kind;
          r_state       <= ST_HOLD;
        end
      end else if (r_state == ST_HOLD) begin
        if (hit) begin
          pc          <= r_pend_target;
          flush       <= 1'b1;
          r_state     <= ST_RUN;
          r_pend_kind <= KIND_NONE;
        end
      end else if (hit) begin
        pc <= pc_next_seq;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module : tb_pc_sequencer
// Brief  : Directed self-checking bench for pc_sequencer (falling-edge design).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

  logic        clock = 1'b1;
  logic        reset, hit;
  logic        branch_valid, jump_valid, exc_valid, eret_valid;
  logic [31:0] branch_target, jump_target, exc_pc;
  logic [31:0] pc, pc_next_seq, epc;
  logic        redirect_pending, flush;
`ifdef PC_ALIGN_CHK_EN
  logic        align_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  pc_sequencer dut (
    .clock            (clock),
    .reset            (reset),
    .hit              (hit),
    .branch_valid     (branch_valid),
    .branch_target    (branch_target),
    .jump_valid       (jump_valid),
    .jump_target      (jump_target),
    .exc_valid        (exc_valid),
    .exc_pc           (exc_pc),
    .eret_valid       (eret_valid),
    .pc               (pc),
    .pc_next_seq      (pc_next_seq),
    .epc              (epc),
    .redirect_pending (redirect_pending),
    .flush            (flush)
`ifdef PC_ALIGN_CHK_EN
    ,
    .align_err        (align_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next falling (active) edge and settle.
  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    branch_valid = 0; jump_valid = 0; exc_valid = 0; eret_valid = 0;
  endtask

  initial begin
    reset = 1; hit = 0; idle();
    branch_target = '0; jump_target = '0; exc_pc = '0;
    tick();
    check("rst_pc", pc, 32'h0);
    check("rst_epc", epc, 32'h0);
    check("rst_pend", 32'(redirect_pending), 32'h0);
    check("rst_flush", 32'(flush), 32'h0);
    reset = 0;

    hit = 1;
    tick(); check("seq_pc4", pc, 32'h4); check("seq_flush", 32'(flush), 32'h0);
    tick(); check("seq_pc8", pc, 32'h8);
    tick(); check("seq_pc12", pc, 32'hC); check("seq_next", pc_next_seq, 32'h10);

    reset = 1; jump_valid = 1; jump_target = 32'h500;
    tick(); check("rst_override", pc, 32'h0);
    reset = 0; idle();

    // Branch during stall gets buffered until hit.
    hit = 0; branch_valid = 1; branch_target = 32'h100;
    tick(); check("hold_pend", 32'(redirect_pending), 32'h1); check("hold_pc0", pc, 32'h0);
    idle();
    tick(); tick();
    check("hold_pc2", pc, 32'h0); check("hold_flush", 32'(flush), 32'h0);
    hit = 1;
    tick();
    check("rel_pc", pc, 32'h100); check("rel_flush", 32'(flush), 32'h1);
    check("rel_pend", 32'(redirect_pending), 32'h0);
    tick(); check("after_rel_pc", pc, 32'h104); check("after_rel_flush", 32'(flush), 32'h0);

    // Jump overwrites pending branch; later branch is dropped.
    hit = 0; branch_valid = 1; branch_target = 32'h100;
    tick(); idle();
    jump_valid = 1; jump_target = 32'h200;
    tick(); idle();
    branch_valid = 1; branch_target = 32'h300;
    tick(); idle();
    check("prio_held", pc, 32'h104);
    hit = 1;
    tick(); check("prio_pc", pc, 32'h200); check("prio_flush", 32'(flush), 32'h1);

    // Overwrite and hit in the same cycle go straight to pc.
    hit = 0; branch_valid = 1; branch_target = 32'h600;
    tick(); idle();
    hit = 1; jump_valid = 1; jump_target = 32'h700;
    tick(); idle();
    check("ovr_hit_pc", pc, 32'h700); check("ovr_hit_pend", 32'(redirect_pending), 32'h0);

    // Exception ignores hit; eret returns to epc.
    hit = 0; exc_valid = 1; exc_pc = 32'h44;
    tick(); idle();
    check("exc_pc", pc, 32'h180); check("exc_epc", epc, 32'h44);
    check("exc_flush", 32'(flush), 32'h1);
    hit = 1;
    tick(); check("exc_seq", pc, 32'h184);
    eret_valid = 1;
    tick(); idle();
    check("eret_pc", pc, 32'h44); check("eret_flush", 32'(flush), 32'h1);

    // Wrap-around of sequential increment.
    jump_valid = 1; jump_target = 32'hFFFF_FFFC;
    tick(); idle();
    check("wrap_top", pc, 32'hFFFF_FFFC); check("wrap_next0", pc_next_seq, 32'h0);
    tick(); check("wrap_pc", pc, 32'h0); check("wrap_next4", pc_next_seq, 32'h4);

    // exc and eret together: exc wins.
    exc_valid = 1; exc_pc = 32'h88; eret_valid = 1;
    tick(); idle();
    check("exc_eret_pc", pc, 32'h180); check("exc_eret_epc", epc, 32'h88);

    // Misaligned jump target.
    jump_valid = 1; jump_target = 32'h102;
    tick(); idle();
`ifdef PC_ALIGN_CHK_EN
    check("align_pc", pc, 32'h180); check("align_epc", epc, 32'h102);
    check("align_err", 32'(align_err), 32'h1);
    hit = 0;
    tick(); check("align_err_clr", 32'(align_err), 32'h0);
`else
    check("noalign_pc", pc, 32'h102); check("noalign_flush", 32'(flush), 32'h1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
